// File: rtl/fft_op_reorder.sv
// fft_op_reorder: consumer end of the r2sdf FFT output stream.
// Two ping-pong banks are written two bit-reversed points per cycle and
// drained in natural order, one point per cycle, under valid/ready.
// Optional build macro REORDER_FRAME_CNT_EN adds a 16-bit frame_cnt output
// that counts accepted frames (each accepted dout_last).
module fft_op_reorder #(
  parameter int N  = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_ready,
  input  logic [DW-1:0] op_raw0,
  input  logic [DW-1:0] op_raw1,
  output logic [DW-1:0] dout,
  output logic [N-1:0]  dout_index,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          overflow,
  output logic          busy
`ifdef REORDER_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);
  localparam int FRAME = 1 << N;
  localparam int BEATS = FRAME / 2;
  localparam logic [N-1:0] LAST_IDX  = N'(FRAME - 1);
  localparam logic [N-1:0] LAST_BEAT = N'(BEATS - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  logic [DW-1:0] mem [2][FRAME];
  bank_t         bank_st   [2];
  bank_t         bank_st_d [2];
  wstate_t       w_state, w_state_d;
  rstate_t       r_state, r_state_d;
  logic          w_bank, w_bank_d;
  logic [N-1:0]  w_beat, w_beat_d;
  logic          old, old_d;
  logic          r_bank, r_bank_d;
  logic [N-1:0]  rd_idx, rd_idx_d;
  logic          rd_done, rd_done_d;
  logic          we, wr_bank;
  logic [N-1:0]  wr_beat, wr_addr0, wr_addr1;
  logic          ovf_set, claim, fill_done;
  logic          load, ld_bank;
  logic [N-1:0]  ld_idx;
  logic          valid_d, acc, pick;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  assign acc      = dout_valid && dout_ready;
  assign busy     = (bank_st[0] != B_EMPTY) || (bank_st[1] != B_EMPTY);
  assign wr_addr0 = bitrev(N'({wr_beat, 1'b0}));
  assign wr_addr1 = bitrev(N'({wr_beat, 1'b1}));
  assign pick     = (bank_st[old] == B_FULL) ? old : !old;

  // Writer next-state: claim a bank, step beats, flag overflow on misuse
  always_comb begin
    w_state_d = w_state;
    w_bank_d  = w_bank;
    w_beat_d  = w_beat;
    old_d     = old;
    we        = 1'b0;
    wr_bank   = w_bank;
    wr_beat   = w_beat;
    ovf_set   = 1'b0;
    claim     = 1'b0;
    fill_done = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (op_ready) begin
          if (bank_st[0] == B_EMPTY || bank_st[1] == B_EMPTY) begin
            claim    = 1'b1;
            we       = 1'b1;
            wr_bank  = (bank_st[0] == B_EMPTY) ? 1'b0 : 1'b1;
            w_bank_d = wr_bank;
            wr_beat  = '0;
            if (BEATS == 1) begin
              fill_done = 1'b1;
            end else begin
              w_state_d = W_FILL;
              w_beat_d  = N'(1);
            end
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      W_FILL: begin
        we = 1'b1;
        if (op_ready) begin
          ovf_set  = 1'b1;
          wr_beat  = '0;
          w_beat_d = N'(1);
        end else if (w_beat == LAST_BEAT) begin
          fill_done = 1'b1;
          w_state_d = W_IDLE;
          w_beat_d  = '0;
        end else begin
          w_beat_d = w_beat + N'(1);
        end
      end
      default: ;
    endcase
    // The bank completing now is the oldest unless the other is still waiting
    if (fill_done && bank_st[!wr_bank] != B_FULL) old_d = wr_bank;
  end

  // Reader and bank next-state; a finished drain chains straight into a FULL
  // peer bank so its index 0 is fetched on the same cycle as the last accept
  always_comb begin
    bank_st_d = bank_st;
    r_state_d = r_state;
    r_bank_d  = r_bank;
    rd_idx_d  = rd_idx;
    rd_done_d = rd_done;
    load      = 1'b0;
    ld_bank   = r_bank;
    ld_idx    = rd_idx;
    valid_d   = dout_valid && !acc;
    if (claim)     bank_st_d[wr_bank] = B_FILLING;
    if (fill_done) bank_st_d[wr_bank] = B_FULL;
    unique case (r_state)
      R_IDLE: begin
        if (bank_st[old] == B_FULL || bank_st[!old] == B_FULL) begin
          bank_st_d[pick] = B_DRAINING;
          r_bank_d        = pick;
          r_state_d       = R_DRAIN;
          rd_idx_d        = '0;
          rd_done_d       = 1'b0;
        end
      end
      R_DRAIN: begin
        if (acc && dout_last) begin
          bank_st_d[r_bank] = B_EMPTY;
          if (bank_st[!r_bank] == B_FULL) begin
            bank_st_d[!r_bank] = B_DRAINING;
            r_bank_d           = !r_bank;
            load               = 1'b1;
            ld_bank            = !r_bank;
            ld_idx             = '0;
          end else begin
            r_state_d = R_IDLE;
          end
        end else if (!rd_done && (!dout_valid || dout_ready)) begin
          load = 1'b1;
        end
      end
      default: ;
    endcase
    if (load) begin
      valid_d   = 1'b1;
      rd_idx_d  = ld_idx + N'(1);
      rd_done_d = (ld_idx == LAST_IDX);
    end
  end

  // State registers, sticky overflow and registered read port
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      w_bank     <= 1'b0;
      w_beat     <= '0;
      old        <= 1'b0;
      r_bank     <= 1'b0;
      rd_idx     <= '0;
      rd_done    <= 1'b0;
      overflow   <= 1'b0;
      dout       <= '0;
      dout_index <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      w_state    <= w_state_d;
      r_state    <= r_state_d;
      bank_st    <= bank_st_d;
      w_bank     <= w_bank_d;
      w_beat     <= w_beat_d;
      old        <= old_d;
      r_bank     <= r_bank_d;
      rd_idx     <= rd_idx_d;
      rd_done    <= rd_done_d;
      dout_valid <= valid_d;
      if (ovf_set) overflow <= 1'b1;
      if (load) begin
        dout       <= mem[ld_bank][ld_idx];
        dout_index <= ld_idx;
        dout_last  <= (ld_idx == LAST_IDX);
      end
    end
  end

  // Dual-lane bank write at bit-reversed addresses
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr0] <= op_raw0;
      mem[wr_bank][wr_addr1] <= op_raw1;
    end
  end

`ifdef REORDER_FRAME_CNT_EN
  // Count frames whose last point was accepted downstream
  always_ff @(posedge clk) begin
    if (!reset)                 frame_cnt <= '0;
    else if (acc && dout_last)  frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fft_op_reorder.sv
// Self-checking bench for fft_op_reorder (N=3, DW=32).
`timescale 1ns/1ps
module tb_fft_op_reorder;
  localparam int N = 3;
  localparam int DW = 32;
  localparam int FRAME = 8;

  typedef logic [DW-1:0] frame_t [FRAME];
  typedef struct {
    logic [DW-1:0] d;
    logic [N-1:0]  i;
    logic          l;
    longint        t;
  } acc_t;

  logic          clk, reset, op_ready, dout_ready;
  logic [DW-1:0] op_raw0, op_raw1, dout;
  logic [N-1:0]  dout_index;
  logic          dout_valid, dout_last, overflow, busy;
`ifdef REORDER_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  acc_t got[$];

  fft_op_reorder #(.N(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .op_ready(op_ready),
    .op_raw0(op_raw0), .op_raw1(op_raw1),
    .dout(dout), .dout_index(dout_index), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last),
    .overflow(overflow), .busy(busy)
`ifdef REORDER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every handshake acceptance, sampled mid-cycle
  always @(negedge clk) begin
    if (dout_valid && dout_ready)
      got.push_back('{dout, dout_index, dout_last, $time});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] rev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; op_ready = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    got.delete();
  endtask

  // Drive nb beats; returns the time of the edge that samples the last beat
  task automatic send_beats(input frame_t f, input int nb, output longint t_last);
    t_last = 0;
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      op_ready = (k == 0);
      op_raw0  = f[rev(N'(2*k))];
      op_raw1  = f[rev(N'(2*k+1))];
      t_last   = $time + 9;
    end
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op_ready = 1'b0; dout_ready = 1'b0;
    op_raw0 = '0; op_raw1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dout !== '0)        begin n_err++; $display("FAIL reset_dout: got %h expected 0", dout); end
    n_cmp++; if (dout_index !== '0)  begin n_err++; $display("FAIL reset_index: got %0d expected 0", dout_index); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    n_cmp++; if (dout_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", dout_last); end
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1 reset = 1'b1;
    got.delete();
  endtask

  task automatic test_basic();
    frame_t f;
    longint tl;
    bit ok;
    for (int i = 0; i < FRAME; i++) f[i] = DW'(32'h11 * i);
    dout_ready = 1'b1;
    send_beats(f, 4, tl);
    wait_got(8, 60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: got %0d outputs expected 8", got.size()); end
    for (int j = 0; j < 8 && j < got.size(); j++) begin
      n_cmp++; if (got[j].d !== f[j]) begin n_err++; $display("FAIL basic_data[%0d]: got %h expected %h", j, got[j].d, f[j]); end
      n_cmp++; if (got[j].i !== N'(j)) begin n_err++; $display("FAIL basic_index[%0d]: got %0d expected %0d", j, got[j].i, j); end
      n_cmp++; if (got[j].l !== (j == 7)) begin n_err++; $display("FAIL basic_last[%0d]: got %b expected %b", j, got[j].l, j == 7); end
      n_cmp++; if (got[j].t !== tl + 25 + 10*j) begin n_err++; $display("FAIL basic_time[%0d]: got %0d expected %0d", j, got[j].t, tl + 25 + 10*j); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
`ifdef REORDER_FRAME_CNT_EN
    @(negedge clk);
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    frame_t f;
    longint tl;
    logic [DW-1:0] hd;
    logic [N-1:0]  hi;
    logic          hl;
    bit held;
    do_reset();
    for (int i = 0; i < FRAME; i++) f[i] = $urandom;
    send_beats(f, 4, tl);
    held = 1'b0; hd = '0; hi = '0; hl = 1'b0;
    for (int c = 0; c < 120 && got.size() < 8; c++) begin
      @(posedge clk); #1;
      dout_ready = (c % 3 == 0);
      @(negedge clk); #1;
      if (held) begin
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %b expected 1", dout_valid); end
        n_cmp++; if (dout !== hd) begin n_err++; $display("FAIL bp_hold_data: got %h expected %h", dout, hd); end
        n_cmp++; if (dout_index !== hi) begin n_err++; $display("FAIL bp_hold_index: got %0d expected %0d", dout_index, hi); end
        n_cmp++; if (dout_last !== hl) begin n_err++; $display("FAIL bp_hold_last: got %b expected %b", dout_last, hl); end
      end
      held = dout_valid && !dout_ready;
      if (held) begin hd = dout; hi = dout_index; hl = dout_last; end
    end
    dout_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", got.size()); end
    for (int j = 0; j < 8 && j < got.size(); j++) begin
      n_cmp++; if (got[j].d !== f[j]) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected %h", j, got[j].d, f[j]); end
      n_cmp++; if (got[j].i !== N'(j)) begin n_err++; $display("FAIL bp_index[%0d]: got %0d expected %0d", j, got[j].i, j); end
    end
  endtask

  task automatic test_ping_pong();
    frame_t f1, f2;
    logic [DW-1:0] exp[$];
    longint tl;
    bit ok;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin f1[i] = $urandom; f2[i] = $urandom; end
    for (int i = 0; i < FRAME; i++) exp.push_back(f1[i]);
    for (int i = 0; i < FRAME; i++) exp.push_back(f2[i]);
    dout_ready = 1'b1;
    send_beats(f1, 4, tl);
    send_beats(f2, 4, tl);
    wait_got(16, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pp_timeout: got %0d outputs expected 16", got.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pp_busy_before: got %b expected 1", busy); end
    for (int j = 0; j < 16 && j < got.size(); j++) begin
      n_cmp++; if (got[j].d !== exp[j]) begin n_err++; $display("FAIL pp_data[%0d]: got %h expected %h", j, got[j].d, exp[j]); end
      n_cmp++; if (got[j].i !== N'(j % FRAME)) begin n_err++; $display("FAIL pp_index[%0d]: got %0d expected %0d", j, got[j].i, j % FRAME); end
      n_cmp++; if (got[j].l !== ((j % FRAME) == FRAME-1)) begin n_err++; $display("FAIL pp_last[%0d]: got %b", j, got[j].l); end
    end
    if (got.size() >= 9) begin
      n_cmp++; if (got[8].t - got[7].t !== 10) begin n_err++; $display("FAIL pp_gap: got %0d ns expected 10", got[8].t - got[7].t); end
    end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pp_busy_after: got %b expected 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    frame_t f1, f2, f3;
    logic [DW-1:0] exp[$];
    longint tl;
    bit ok;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin f1[i] = $urandom; f2[i] = $urandom; f3[i] = $urandom; end
    for (int i = 0; i < FRAME; i++) exp.push_back(f1[i]);
    for (int i = 0; i < FRAME; i++) exp.push_back(f2[i]);
    dout_ready = 1'b0;
    send_beats(f1, 4, tl);
    send_beats(f2, 4, tl);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    send_beats(f3, 4, tl);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid_waiting: got %b expected 1", dout_valid); end
    @(posedge clk); #1 dout_ready = 1'b1;
    wait_got(16, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: got %0d outputs expected 16", got.size()); end
    repeat (20) @(negedge clk);
    #1;
    n_cmp++; if (got.size() !== 16) begin n_err++; $display("FAIL ovf_count: got %0d expected 16", got.size()); end
    for (int j = 0; j < 16 && j < got.size(); j++) begin
      n_cmp++; if (got[j].d !== exp[j]) begin n_err++; $display("FAIL ovf_data[%0d]: got %h expected %h", j, got[j].d, exp[j]); end
    end
  endtask

  task automatic test_restart();
    frame_t junk, fa;
    longint tl;
    bit ok;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin junk[i] = $urandom; fa[i] = DW'(32'hA0 + i); end
    dout_ready = 1'b1;
    send_beats(junk, 2, tl);
    send_beats(fa, 4, tl);
    wait_got(8, 60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rs_timeout: got %0d outputs expected 8", got.size()); end
    repeat (20) @(negedge clk);
    #1;
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL rs_count: got %0d expected 8", got.size()); end
    for (int j = 0; j < 8 && j < got.size(); j++) begin
      n_cmp++; if (got[j].d !== fa[j]) begin n_err++; $display("FAIL rs_data[%0d]: got %h expected %h", j, got[j].d, fa[j]); end
      n_cmp++; if (got[j].i !== N'(j)) begin n_err++; $display("FAIL rs_index[%0d]: got %0d expected %0d", j, got[j].i, j); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rs_overflow: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid_drain();
    frame_t f1, f2;
    longint tl;
    bit ok, seen;
    got.delete();
    for (int i = 0; i < FRAME; i++) begin f1[i] = $urandom; f2[i] = $urandom; end
    dout_ready = 1'b1;
    send_beats(f1, 4, tl);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dout_valid && dout_index == N'(3)) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rmd_index3_timeout: index 3 never presented"); end
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (dout !== '0)         begin n_err++; $display("FAIL rmd_dout: got %h expected 0", dout); end
    n_cmp++; if (dout_index !== '0)   begin n_err++; $display("FAIL rmd_index: got %0d expected 0", dout_index); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rmd_valid: got %b expected 0", dout_valid); end
    n_cmp++; if (dout_last !== 1'b0)  begin n_err++; $display("FAIL rmd_last: got %b expected 0", dout_last); end
    n_cmp++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL rmd_overflow: got %b expected 0", overflow); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rmd_busy: got %b expected 0", busy); end
`ifdef REORDER_FRAME_CNT_EN
    n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rmd_frame_cnt_reset: got %0d expected 0", frame_cnt); end
`endif
    @(posedge clk); #1 reset = 1'b1;
    got.delete();
    send_beats(f2, 4, tl);
    wait_got(8, 60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmd_timeout: got %0d outputs expected 8", got.size()); end
    for (int j = 0; j < 8 && j < got.size(); j++) begin
      n_cmp++; if (got[j].d !== f2[j]) begin n_err++; $display("FAIL rmd_data[%0d]: got %h expected %h", j, got[j].d, f2[j]); end
      n_cmp++; if (got[j].i !== N'(j)) begin n_err++; $display("FAIL rmd_index[%0d]: got %0d expected %0d", j, got[j].i, j); end
    end
    @(negedge clk);
`ifdef REORDER_FRAME_CNT_EN
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL rmd_frame_cnt: got %0d expected 1", frame_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ping_pong();
    test_overflow();
    test_restart();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_op_reorder.md
Name: fft_op_reorder

Overview:
- Consumer end of the r2sdf FFT output stream. Captures 2^N points per frame, arriving two per cycle in bit-reversed order on the raw output lanes.
- Emits the frame in natural order, one point per cycle, under a valid/ready handshake.
- Ping-pong buffered: one bank fills from the FFT while the other drains downstream. It replaces the FFT's internal shuffling for consumers that can stall.

Parameters:
- N, 3, log2 of FFT length; frame = 2^N points, 2^(N-1) input beats.
- DW, 32, width of one fpt sample word.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- op_ready  in  1  one-cycle pulse marking beat 0 of a frame; beats continue on the following consecutive cycles without gaps.
- op_raw0  in  DW  lane 0 (op_raw[0]); on beat k carries natural index bitrev_N(2k).
- op_raw1  in  DW  lane 1 (op_raw[1]); on beat k carries natural index bitrev_N(2k+1).
- dout  out  DW  reordered sample.
- dout_index  out  N  natural index of dout.
- dout_valid  out  1  dout, dout_index and dout_last are valid.
- dout_ready  in  1  downstream accepts when dout_valid && dout_ready.
- dout_last  out  1  high with index 2^N-1.
- overflow  out  1  sticky error flag; cleared only by reset.
- busy  out  1  any bank not EMPTY.

Behaviour:
- Storage: two banks of 2^N x DW, dual write (two lanes per cycle), single read. Each bank has a state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Writer FSM (W_IDLE, W_FILL):
  - op_ready in W_IDLE with an EMPTY bank: take the lowest-numbered EMPTY bank, mark it FILLING, write beat 0 this cycle, go to W_FILL.
  - In W_FILL: beat k writes op_raw0 at addr bitrev(2k) and op_raw1 at addr bitrev(2k+1), with k counting from 0.
  - After beat 2^(N-1)-1: bank becomes FULL; return to W_IDLE.
  - N=1 edge case: the single beat is beat 0, so the bank becomes FULL in the same cycle and the writer stays in W_IDLE.
- Writer error cases (the writer never stalls the FFT):
  - op_ready with no EMPTY bank: set overflow, drop the whole frame, stay in W_IDLE.
  - op_ready during W_FILL: set overflow, discard the partial frame in that bank, restart at beat 0 in the same bank.
- Reader FSM (R_IDLE, R_DRAIN):
  - Drains the oldest FULL bank in order 0..2^N-1.
  - Reads are registered: dout_valid first rises 2 cycles after the last write beat, with index 0 (1 cycle for the FULL transition, 1 cycle for the RAM read).
  - Holds dout, dout_index and dout_last stable while dout_valid && !dout_ready.
  - On acceptance the next index is presented the following cycle, giving 1 point/cycle at full ready.
  - Acceptance of index 2^N-1 sets the bank EMPTY and the reader returns to R_IDLE.
  - If the other bank is already FULL, its index 0 is valid on the cycle after that acceptance (no bubble beyond the read latency).
- Simultaneous events:
  - A bank freed by the reader in the same cycle as op_ready is not yet EMPTY to the writer; the writer uses the other bank if EMPTY, otherwise overflow applies.
  - Writer completion and a reader start on the same bank cannot coincide, because FULL is visible only the next cycle.
- Frame ordering: frames drain in arrival order (1-bit oldest-bank pointer).
- Reset (any time, including mid-frame or mid-drain): both banks EMPTY, both FSMs idle. All outputs are 0: dout, dout_index, dout_valid, dout_last, overflow, busy. RAM contents need not be cleared.

Optional Feature:
- Macro REORDER_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (out, 16 bits). It resets to 0, increments on each accepted dout_last and wraps from 0xFFFF to 0. Frames dropped or aborted by overflow are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic reorder, N=3, dout_ready=1: reset low 2 cycles. Pulse op_ready and send beats (lane0, lane1) = (0x00,0x44), (0x22,0x66), (0x11,0x55), (0x33,0x77). Required: dout = 0x00,0x11,...,0x77 with dout_index 0..7 on consecutive cycles; first valid 2 cycles after beat 3; dout_last only with index 7; overflow=0.
- Backpressure: same frame, dout_ready toggled 1,0,0,1,...: no index skipped or repeated; dout held stable while stalled; 8 acceptances total.
- Ping-pong: two frames back-to-back with dout_ready=1. Required: 16 outputs in order; the second frame's index 0 follows the first frame's index 7 with no extra gap; overflow=0; busy falls after the last acceptance.
- Overflow, no bank: dout_ready=0, send 3 frames. Required: overflow=1 from the third op_ready; after releasing ready, only frames 1 and 2 are emitted.
- Restart mid-frame: op_ready again at beat 2, then a full frame of 0xA0..0xA7 in bit-reversed order. Required: overflow=1; output is exactly 0xA0..0xA7; no partial data.
- Reset mid-drain: assert reset during index 3 of a drain. Required: next cycle all outputs are 0 and busy=0; a following frame drains correctly from index 0. With REORDER_FRAME_CNT_EN defined, frame_cnt reads 0 after reset and 1 after that frame.
